// File: rtl/fifo_rd_ctrl.sv
// Burst read controller draining a first-word-fall-through FIFO into a valid/ready stream.
// Build option: define FIFO_RD_CTRL_TIMEOUT_EN to add the underflow stall timeout and sticky err flag.
module fifo_rd_ctrl #(
    parameter int bw   = 4,
    parameter int simd = 1
) (
    input  logic                 rd_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [6:0]           burst_len,
    input  logic                 rewind,
    input  logic                 fifo_empty,
    input  logic [simd*bw-1:0]   fifo_data,
    output logic                 fifo_rd,
    output logic                 fifo_flush_rd_ptr,
    output logic [simd*bw-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic [6:0]           rd_count,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [6:0]           remaining_r;
    logic [6:0]           rd_count_r;
    logic [simd*bw-1:0]   m_data_r;
    logic                 m_valid_r;
    logic                 pop_s;
    logic                 flush_s;
    logic                 accept_s;
    logic                 len_ok_s;
    logic                 timeout_s;

    assign len_ok_s = (burst_len != 7'd0) && (burst_len <= 7'd64);

    // Next-state decode plus the pop/flush strobes that only exist in specific states
    always_comb begin
        state_s  = state_r;
        pop_s    = 1'b0;
        flush_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (rewind) begin
                    flush_s = 1'b1;
                end else if (start) begin
                    accept_s = 1'b1;
                    state_s  = len_ok_s ? READ : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                pop_s = ~fifo_empty & (remaining_r != 7'd0) & (~m_valid_r | m_ready);
                if (pop_s && (remaining_r == 7'd1)) begin
                    state_s = DRAIN;
                end else if (timeout_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (~m_valid_r | m_ready) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Burst bookkeeping and the output skid register; a pop refills it in the same edge it drains
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            remaining_r <= 7'd0;
            rd_count_r  <= 7'd0;
            m_data_r    <= '0;
            m_valid_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                remaining_r <= len_ok_s ? burst_len : 7'd0;
                rd_count_r  <= 7'd0;
            end else if (pop_s) begin
                remaining_r <= remaining_r - 7'd1;
                rd_count_r  <= rd_count_r + 7'd1;
            end else begin
                remaining_r <= remaining_r;
                rd_count_r  <= rd_count_r;
            end
            if (pop_s) begin
                m_data_r  <= fifo_data;
                m_valid_r <= 1'b1;
            end else if (m_valid_r && m_ready) begin
                m_valid_r <= 1'b0;
            end else begin
                m_valid_r <= m_valid_r;
            end
        end
    end

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
    logic [7:0] stall_r;
    logic       err_r;

    // The 255th consecutive empty READ cycle is the one that trips the timeout
    assign timeout_s = (state_r == READ) && fifo_empty && (stall_r == 8'd254);

    // Stall counter and sticky error flag
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            stall_r <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            if ((state_s != READ) || pop_s) begin
                stall_r <= 8'd0;
            end else if (fifo_empty) begin
                stall_r <= stall_r + 8'd1;
            end else begin
                stall_r <= stall_r;
            end
            err_r <= err_r | timeout_s;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    assign fifo_rd           = pop_s & ~reset;
    assign fifo_flush_rd_ptr = flush_s & ~reset;
    assign m_data            = m_data_r;
    assign m_valid           = m_valid_r;
    assign rd_count          = rd_count_r;
    assign busy              = (state_r != IDLE);
    assign done              = (state_r == DONE);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a queue-backed FIFO model feeds the DUT, a monitor checks every beat.
// The timeout scenario follows FIFO_RD_CTRL_TIMEOUT_EN as the RTL does.
module tb_fifo_rd_ctrl;
    localparam int BW   = 4;
    localparam int SIMD = 1;
    localparam int W    = BW * SIMD;

    logic           rd_clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [6:0]     burst_len = 7'd0;
    logic           rewind = 1'b0;
    logic           fifo_empty = 1'b1;
    logic [W-1:0]   fifo_data = '0;
    logic           m_ready = 1'b1;
    logic           fifo_rd;
    logic           fifo_flush_rd_ptr;
    logic [W-1:0]   m_data;
    logic           m_valid;
    logic           busy;
    logic           done;
    logic [6:0]     rd_count;
    logic           err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_beats = 0;
    int n_pops = 0;
    int n_done = 0;
    int n_flush = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc = 0;
    int last_beat_cyc = 0;
    int done_cyc = 0;
    bit pop_seen = 1'b0;
    bit prev_done = 1'b0;
    bit toggle_mode = 1'b0;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_word;

    fifo_rd_ctrl #(.bw(BW), .simd(SIMD)) dut (
        .rd_clk(rd_clk), .reset(reset), .start(start), .burst_len(burst_len),
        .rewind(rewind), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .fifo_flush_rd_ptr(fifo_flush_rd_ptr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .rd_count(rd_count), .err(err)
    );

    initial forever #5 rd_clk = ~rd_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIFO model: applies the pop seen last cycle, then presents the new head
    initial forever begin
        @(posedge rd_clk);
        cyc++;
        #2;
        if (pop_seen && fifo_q.size() > 0) fifo_q.delete(0);
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Downstream ready pattern
    initial forever begin
        @(posedge rd_clk);
        #1;
        m_ready = toggle_mode ? ~m_ready : 1'b1;
    end

    // Monitor: scoreboard comparison of accepted beats plus protocol checks
    initial forever begin
        @(negedge rd_clk);
        if (m_valid && m_ready) begin
            chk("beat_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                chk("beat_data", int'(m_data), int'(exp_word));
            end
            n_beats++;
            last_beat_cyc = cyc;
        end
        if (m_valid && !m_ready) chk("no_pop_while_held", int'(fifo_rd), 0);
        if (fifo_rd) begin
            chk("pop_nonempty", int'(fifo_empty), 0);
            n_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        pop_seen = fifo_rd;
        if (done) begin
            chk("done_one_cycle", int'(prev_done), 0);
            n_done++;
            done_cyc = cyc;
        end
        prev_done = done;
        if (fifo_flush_rd_ptr) n_flush++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #3;
        end
    endtask

    task automatic push_words(input int n, input int seed);
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = W'(seed + i * 3);
            fifo_q.push_back(d);
            exp_q.push_back(d);
        end
    endtask

    task automatic do_start(input int len);
        burst_len = 7'(len);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0 = n_done;
        int k = 0;
        while (n_done == d0 && k < limit) begin
            tick(1);
            k++;
        end
        chk("done_within_budget", int'(n_done > d0), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_rd_count"}, int'(rd_count), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_fifo_rd"}, int'(fifo_rd), 0);
        chk({tag, "_flush"}, int'(fifo_flush_rd_ptr), 0);
    endtask

    initial begin
        int b0, p0, d0, f0, k;
        int bad_lens[2] = '{0, 65};

        tick(3);
        @(negedge rd_clk);
        check_reset_outputs("reset");
        tick(1);
        reset = 1'b0;
        tick(1);

        // Four-word burst at full throughput
        push_words(4, 1);
        b0 = n_beats; p0 = n_pops; first_pop_cyc = -1;
        do_start(4);
        wait_done(50);
        chk("t1_pops", n_pops - p0, 4);
        chk("t1_pops_consecutive", last_pop_cyc - first_pop_cyc, 3);
        chk("t1_beats", n_beats - b0, 4);
        chk("t1_done_after_last_beat", done_cyc - last_beat_cyc, 1);
        chk("t1_rd_count", int'(rd_count), 4);

        // Out-of-range lengths finish immediately with no pops
        foreach (bad_lens[i]) begin
            p0 = n_pops; d0 = n_done;
            do_start(bad_lens[i]);
            @(negedge rd_clk);
            chk("badlen_done", int'(done), 1);
            chk("badlen_busy", int'(busy), 1);
            tick(1);
            chk("badlen_idle", int'(busy), 0);
            chk("badlen_no_pops", n_pops - p0, 0);
            chk("badlen_one_done", n_done - d0, 1);
            chk("badlen_rd_count", int'(rd_count), 0);
        end

        // Three words under alternating backpressure
        toggle_mode = 1'b1;
        push_words(3, 7);
        b0 = n_beats;
        do_start(3);
        wait_done(60);
        toggle_mode = 1'b0;
        chk("t2_beats", n_beats - b0, 3);
        chk("t2_rd_count", int'(rd_count), 3);
        chk("t2_scoreboard_empty", exp_q.size(), 0);

        // 64-word burst with the FIFO running dry for ten cycles
        push_words(20, 2);
        b0 = n_beats;
        do_start(64);
        k = 0;
        while (fifo_q.size() > 0 && k < 200) begin
            tick(1);
            k++;
        end
        chk("t3_fifo_drained", fifo_q.size(), 0);
        p0 = n_pops;
        tick(10);
        chk("t3_stall_no_pops", n_pops - p0, 0);
        chk("t3_stall_busy", int'(busy), 1);
        push_words(44, 5);
        wait_done(200);
        chk("t3_beats", n_beats - b0, 64);
        chk("t3_rd_count", int'(rd_count), 64);
        chk("t3_err", int'(err), 0);
        chk("t3_scoreboard_empty", exp_q.size(), 0);

        // Rewind beats start, then start alone runs
        f0 = n_flush;
        rewind = 1'b1; start = 1'b1; burst_len = 7'd3;
        @(negedge rd_clk);
        chk("t4_flush", int'(fifo_flush_rd_ptr), 1);
        chk("t4_busy_on_rewind", int'(busy), 0);
        tick(1);
        rewind = 1'b0; start = 1'b1; burst_len = 7'd2;
        push_words(2, 9);
        @(negedge rd_clk);
        chk("t4_flush_cleared", int'(fifo_flush_rd_ptr), 0);
        chk("t4_still_idle", int'(busy), 0);
        tick(1);
        start = 1'b0;
        chk("t4_flush_count", n_flush - f0, 1);
        @(negedge rd_clk);
        chk("t4_busy", int'(busy), 1);
        wait_done(50);
        chk("t4_rd_count", int'(rd_count), 2);
        chk("t4_scoreboard_empty", exp_q.size(), 0);

        // Reset after two of eight pops
        push_words(8, 4);
        p0 = n_pops; d0 = n_done;
        do_start(8);
        k = 0;
        while (n_pops - p0 < 2 && k < 50) begin
            tick(1);
            k++;
        end
        chk("t5_two_pops", n_pops - p0, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        @(negedge rd_clk);
        check_reset_outputs("t5");
        tick(3);
        chk("t5_no_done", n_done - d0, 0);
        chk("t5_idle", int'(busy), 0);

        // Underflow: five requested, two available
        push_words(2, 11);
        b0 = n_beats;
        do_start(5);
`ifdef FIFO_RD_CTRL_TIMEOUT_EN
        wait_done(400);
        chk("t6_err", int'(err), 1);
        chk("t6_beats", n_beats - b0, 2);
        chk("t6_rd_count", int'(rd_count), 2);
        exp_q.delete();
`else
        tick(300);
        chk("t6_busy", int'(busy), 1);
        chk("t6_err", int'(err), 0);
        chk("t6_beats", n_beats - b0, 2);
        chk("t6_rd_count", int'(rd_count), 2);
        push_words(3, 13);
        wait_done(50);
        chk("t6_rd_count_final", int'(rd_count), 5);
        chk("t6_scoreboard_empty", exp_q.size(), 0);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameters: bw, 4, bits per lane; simd, 1, lanes per FIFO word.
REQ-002 rd_clk  input  1  read-side clock; all state updates on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock rd_clk.
REQ-004 start  input  1  begin a burst read; sampled in IDLE only.
REQ-005 burst_len  input  7  entries per burst, 1..64; sampled with start.
REQ-006 rewind  input  1  request FIFO read-pointer flush; sampled in IDLE only.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_data  input  simd*bw  FIFO head word (first-word fall-through, valid whenever fifo_empty=0).
REQ-009 fifo_rd  output  1  pop strobe to FIFO.
REQ-010 fifo_flush_rd_ptr  output  1  FIFO read-pointer flush strobe.
REQ-011 m_data  output  simd*bw  downstream data.
REQ-012 m_valid  output  1  m_data valid.
REQ-013 m_ready  input  1  downstream accept.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle burst-complete pulse.
REQ-016 rd_count  output  7  entries popped in current or last burst.
REQ-017 err  output  1  sticky underflow-timeout flag.

Function
REQ-018 FSM states IDLE, READ, DRAIN, DONE; DONE->IDLE unconditionally after one cycle.
REQ-019 IDLE: rewind=1 -> fifo_flush_rd_ptr=1 combinationally that cycle, stay IDLE; rewind has priority over start, which is then ignored.
REQ-020 IDLE: start=1, rewind=0, burst_len in 1..64 -> latch burst_len into remaining, clear rd_count, go READ next cycle.
REQ-021 IDLE: start=1 with burst_len=0 or >64 -> go DONE directly, zero pops.
REQ-022 fifo_rd = (state==READ) & ~fifo_empty & (remaining!=0) & (~m_valid | m_ready); combinational, never high outside READ.
REQ-023 On fifo_rd: m_data <= fifo_data, m_valid <= 1, remaining decrements, rd_count increments; one pop per cycle max.
REQ-024 m_valid&m_ready without a same-cycle pop -> m_valid <= 0; m_data holds while m_valid&~m_ready.
REQ-025 Latency: first pop earliest in first READ cycle; m_valid rises the cycle after each pop; full throughput one word/cycle with m_ready held high.
REQ-026 READ->DRAIN on the edge the last pop occurs (remaining 1->0).
REQ-027 DRAIN->DONE when m_valid=0, or m_valid&m_ready (last word accepted).
REQ-028 done=1 exactly in DONE; busy=0 only in IDLE.
REQ-029 start/rewind while busy are ignored.
REQ-030 FIFO empty in READ: stall, no pop, no state change (except REQ-036).

Reset
REQ-031 reset wins over all inputs; next state IDLE.
REQ-032 Reset values: m_valid=0, m_data=0, rd_count=0, remaining=0, done=0, busy=0, err=0, fifo_rd=0, fifo_flush_rd_ptr=0.
REQ-033 Reset mid-burst discards in-flight m_data; no done pulse issued.

Configuration
REQ-034 Macro FIFO_RD_CTRL_TIMEOUT_EN selects underflow timeout.
REQ-035 Defined: 8-bit stall counter increments each READ cycle with fifo_empty=1, clears on any pop or on leaving READ.
REQ-036 Defined: counter reaching 255 -> err <= 1 (sticky until reset), READ->DRAIN abandoning remaining entries.
REQ-037 Undefined: no stall counter; err tied 0; READ waits indefinitely.

Verification
REQ-038 burst_len=4, FIFO holds 4, m_ready=1 -> fifo_rd high 4 consecutive cycles, 4 m_valid beats in order, done 1 cycle after last beat, rd_count=4.
REQ-039 burst_len=3, m_ready toggles 1/0 -> no word lost/duplicated, fifo_rd never high while m_valid&~m_ready, rd_count=3.
REQ-040 burst_len=64 with FIFO empty for 10 cycles mid-burst -> stall, no pops, resume; 64 words out, err=0.
REQ-041 rewind and start same IDLE cycle -> fifo_flush_rd_ptr=1 one cycle, busy stays 0; start alone next cycle runs normally.
REQ-042 reset asserted after 2 of 8 pops -> next cycle all outputs at reset values, no done.
REQ-043 With FIFO_RD_CTRL_TIMEOUT_EN, burst_len=5, FIFO holds 2 -> 2 words out, err=1 after 255 empty cycles, done pulse; without macro busy stays 1, err=0.
